// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: opcodes, interrupt opcode, cycle width and T-state constants shared by decoder and timing logic
package cpu6502_pkg;
  localparam int CYCW = 3;
  localparam logic [7:0] INT_OPCODE = 8'h00;
  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_RTI     = 8'h40;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [CYCW-1:0] T0 = 3'd0;
  localparam logic [CYCW-1:0] T1 = 3'd1;
  localparam logic [CYCW-1:0] T2 = 3'd2;
  localparam logic [CYCW-1:0] T3 = 3'd3;
  localparam logic [CYCW-1:0] T4 = 3'd4;
  localparam logic [CYCW-1:0] T5 = 3'd5;
  localparam logic [CYCW-1:0] T6 = 3'd6;
  localparam logic [CYCW-1:0] T7 = 3'd7;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-flop single-bit synchroniser (clk, async clear clr, async input d, synchronised output q)
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [N-1:0] s;
  always_ff @(posedge clk or posedge clr)
    if (clr) s <= '0;
    else s <= {s[N-2:0], d};
  assign q = s[N-1];
endmodule

// File: rtl/inst_timing.sv
// inst_timing: instruction register, T-state counter and rst/nmi/irq pending flags feeding the decoder (in: clk clr databus icyc rcyc sinst irqdis irq_in nmi_in; out: inst cycle rstpend nmipend irqpend sync cycerr)
module inst_timing #(
  parameter logic [7:0] INT_OPCODE = cpu6502_pkg::INT_OPCODE,
  parameter int CYCW = cpu6502_pkg::CYCW,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [7:0]      databus,
  input  logic            icyc,
  input  logic            rcyc,
  input  logic            sinst,
  input  logic            irqdis,
  input  logic            irq_in,
  input  logic            nmi_in,
  output logic [7:0]      inst,
  output logic [CYCW-1:0] cycle,
  output logic            rstpend,
  output logic            nmipend,
  output logic            irqpend,
  output logic            sync,
  output logic            cycerr
);
  logic irq_s, nmi_s, nmi_q;
  logic pend, nmi_edge, ack_rst, ack_nmi, ack_irq;
  bit_sync #(.N(SYNC_STAGES)) u_irq_sync (.clk(clk), .clr(clr), .d(irq_in), .q(irq_s));
  bit_sync #(.N(SYNC_STAGES)) u_nmi_sync (.clk(clk), .clr(clr), .d(nmi_in), .q(nmi_s));
  always_comb begin
    pend = rstpend | nmipend | irqpend;
    nmi_edge = nmi_s & ~nmi_q;
    ack_rst = sinst & rstpend;
    ack_nmi = sinst & ~rstpend & nmipend;
    ack_irq = sinst & ~rstpend & ~nmipend;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      inst <= INT_OPCODE;
      cycle <= '0;
      rstpend <= 1'b1;
      nmipend <= 1'b0;
      irqpend <= 1'b0;
      sync <= 1'b0;
      cycerr <= 1'b0;
      nmi_q <= 1'b0;
    end else begin
      cycle <= rcyc ? '0 : cycle + CYCW'(icyc);
      cycerr <= cycerr | (icyc & ~rcyc & (&cycle));
      if (rcyc) inst <= pend ? INT_OPCODE : databus;
      sync <= rcyc;
      nmi_q <= nmi_s;
      rstpend <= rstpend & ~ack_rst;
      // a fresh NMI edge beats a coincident acknowledge so it is not lost
      nmipend <= nmi_edge | (nmipend & ~ack_nmi);
      irqpend <= irq_s & ~irqdis & ~ack_irq;
    end
endmodule

// File: tb/tb_inst_timing.sv
// tb_inst_timing: scoreboard bench for inst_timing against a sample-history reference model
module tb_inst_timing;
  localparam int S = 2;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [7:0] databus = 8'h00;
  logic icyc = 1'b0, rcyc = 1'b0, sinst = 1'b0, irqdis = 1'b0, irq_in = 1'b0, nmi_in = 1'b0;
  logic [7:0] inst;
  logic [2:0] cycle;
  logic rstpend, nmipend, irqpend, sync, cycerr;
  always #5 clk = ~clk;
  inst_timing #(.INT_OPCODE(8'h00), .CYCW(3), .SYNC_STAGES(S)) dut (
    .clk(clk), .clr(clr), .databus(databus), .icyc(icyc), .rcyc(rcyc), .sinst(sinst),
    .irqdis(irqdis), .irq_in(irq_in), .nmi_in(nmi_in), .inst(inst), .cycle(cycle),
    .rstpend(rstpend), .nmipend(nmipend), .irqpend(irqpend), .sync(sync), .cycerr(cycerr)
  );
  typedef struct {
    int inst, cycle, rp, np, ip, sy, ce;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  int m_inst, m_cycle;
  bit m_rp, m_np, m_ip, m_sync, m_err;
  bit ih[$], nh[$];
  bit irq_v = 0, nmi_v = 0;
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_inst = 8'h00; m_cycle = 0; m_rp = 1; m_np = 0; m_ip = 0; m_sync = 0; m_err = 0;
    ih = {}; nh = {};
    for (int i = 0; i <= S; i++) begin ih.push_back(1'b0); nh.push_back(1'b0); end
  endfunction
  task automatic check_now();
    chk("inst", int'(inst), m_inst);
    chk("cycle", int'(cycle), m_cycle);
    chk("rstpend", int'(rstpend), int'(m_rp));
    chk("nmipend", int'(nmipend), int'(m_np));
    chk("irqpend", int'(irqpend), int'(m_ip));
    chk("sync", int'(sync), int'(m_sync));
    chk("cycerr", int'(cycerr), int'(m_err));
  endtask
  // ih/nh hold the lines as sampled at past edges, newest first: the synchronised
  // level seen at an edge is the sample S edges earlier
  task automatic step(input bit ic, input bit rc, input bit si, input bit dis, input logic [7:0] db);
    bit pend, a_r, a_n, a_i, ne, is;
    @(negedge clk);
    clr = 0; icyc = ic; rcyc = rc; sinst = si; irqdis = dis; databus = db;
    irq_in = irq_v; nmi_in = nmi_v;
    pend = m_rp | m_np | m_ip;
    a_r = si && m_rp;
    a_n = si && !m_rp && m_np;
    a_i = si && !m_rp && !m_np;
    ne = nh[S-1] && !nh[S];
    is = ih[S-1];
    m_rp = m_rp && !a_r;
    m_np = ne || (m_np && !a_n);
    m_ip = is && !dis && !a_i;
    if (rc) begin
      m_inst = pend ? 8'h00 : int'(db);
      m_cycle = 0;
    end else if (ic) begin
      if (m_cycle == 7) begin m_cycle = 0; m_err = 1; end
      else m_cycle = m_cycle + 1;
    end
    m_sync = rc;
    ih.push_front(irq_v); void'(ih.pop_back());
    nh.push_front(nmi_v); void'(nh.pop_back());
    q.push_back('{m_inst, m_cycle, int'(m_rp), int'(m_np), int'(m_ip), int'(m_sync), int'(m_err)});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, irqdis, 8'h00);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 clr = 1;
    #1 model_reset();
    check_now();
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("inst", int'(inst), e.inst);
      chk("cycle", int'(cycle), e.cycle);
      chk("rstpend", int'(rstpend), e.rp);
      chk("nmipend", int'(nmipend), e.np);
      chk("irqpend", int'(irqpend), e.ip);
      chk("sync", int'(sync), e.sy);
      chk("cycerr", int'(cycerr), e.ce);
    end
  end
  initial begin
    #2 clr = 1;
    #1 model_reset();
    check_now();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h00);
    do_reset();
    step(0, 0, 1, 0, 8'h00);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'hA9);
    idle(2);
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h33);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'h00);
    idle(3);
    nmi_v = 1;
    idle(3);
    step(0, 1, 0, 0, 8'hEA);
    step(0, 0, 1, 0, 8'h00);
    idle(4);
    nmi_v = 0;
    idle(3);
    nmi_v = 1;
    idle(1);
    nmi_v = 0;
    idle(4);
    nmi_v = 1;
    idle(2);
    step(0, 0, 1, 0, 8'h00);
    idle(2);
    step(0, 0, 1, 0, 8'h00);
    nmi_v = 0;
    irq_v = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h69);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h55);
    idle(1);
    do_reset();
    nmi_v = 1;
    idle(4);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    idle(2);
    irq_v = 0; nmi_v = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) irq_v = ~irq_v;
      if ($urandom_range(0, 7) == 0) nmi_v = ~nmi_v;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, 8'($urandom));
    end
    repeat (3) @(posedge clk);
    #2 chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
